// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a valid/ready FIFO feeds an LSB-first serialiser with
// run-time parity (none/even/odd) and one or two stop bits, frames sent back-to-back.
module uart_tx_buffered #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned CLK_FREQ      = 50,
    parameter int unsigned BAUD_RATE     = 10,
    parameter int unsigned BAUD_RATE_DIV = CLK_FREQ / BAUD_RATE,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DATA_BITS-1:0]        tx_data_in,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    output logic                        tx_serial_out,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(BAUD_RATE_DIV);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic                 fifo_empty, fifo_full, push, pop, load;
    logic                 bit_tick, last_data, last_stop;
    logic [DATA_BITS-1:0] fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign tx_ready   = reset_n && !fifo_full;
    assign push       = tx_valid && tx_ready;
    assign fifo_head  = mem_q[rd_ptr_q];

    assign bit_tick  = (cnt_q == BAUD_W'(BAUD_RATE_DIV - 1));
    assign last_data = (bit_idx_q == IDX_W'(DATA_BITS - 1));
    assign last_stop = (state_q == S_STOP) && bit_tick && (stop_idx_q || !stop2_q);
    // A new frame is taken from idle or on the very edge that ends the previous one.
    assign load      = !fifo_empty && ((state_q == S_IDLE) || last_stop);
    assign pop       = load;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx_data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (load) state_d = S_START;
            S_START:  if (bit_tick) state_d = S_DATA;
            S_DATA:   if (bit_tick && last_data) state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_d = S_STOP;
            S_STOP:   if (last_stop) state_d = load ? S_START : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = (state_q == S_IDLE || bit_tick) ? '0 : cnt_q + BAUD_W'(1);
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        serial_d   = serial_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = last_stop;
        if (load) begin
            shift_d    = fifo_head;
            par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d  = (^fifo_head) ^ (parity_mode == 2'b10);
            stop2_d    = stop2;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            serial_d   = 1'b0;
        end else if (bit_tick) begin
            unique case (state_q)
                S_START: begin
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
                S_DATA: begin
                    if (last_data) begin
                        serial_d = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        serial_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                S_PARITY: serial_d = 1'b1;
                S_STOP: begin
                    serial_d   = 1'b1;
                    stop_idx_d = 1'b1;
                end
                default: serial_d = 1'b1;
            endcase
        end
    end

    assign tx_serial_out = serial_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: random bytes are compared cycle by cycle
// against a frame-level line model and, for the wrap test, an independent receiver.
module tb_uart_tx_buffered;
    localparam int unsigned DIV   = 5;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data_in;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx_serial_out;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit rx_en = 1'b0;
    bit rx_prev;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    bit exp_line[$];
    bit exp_busy[$];
    bit exp_done[$];

    uart_tx_buffered #(
        .DATA_BITS(8), .CLK_FREQ(50), .BAUD_RATE(10), .BAUD_RATE_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tx_data_in(tx_data_in), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .parity_mode(parity_mode), .stop2(stop2),
        .tx_serial_out(tx_serial_out), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt = done_cnt + 1;

    // Independent 8N1 receiver: sample each bit in the middle of its period.
    initial begin
        rx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_en && rx_prev && tx_serial_out === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(negedge clk);
                    rx_byte[b] = tx_serial_out;
                end
                repeat (DIV) @(negedge clk);
                rx_q.push_back(rx_byte);
            end
            rx_prev = (tx_serial_out === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Line model: a frame is its bit list, each bit held DIV cycles.
    function automatic void model_frame(input logic [7:0] d, input logic [1:0] pm,
                                        input bit s2, input bit first);
        bit bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (pm == 2'b01) bits.push_back(bit'(($countones(d) % 2) == 1));
        if (pm == 2'b10) bits.push_back(bit'(($countones(d) % 2) == 0));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < int'(DIV); c++) begin
                exp_line.push_back(bits[k]);
                exp_busy.push_back(1'b1);
                exp_done.push_back(!first && k == 0 && c == 0);
            end
        end
    endfunction

    function automatic void model_tail();
        exp_line.push_back(1'b1);
        exp_busy.push_back(1'b0);
        exp_done.push_back(1'b1);
    endfunction

    function automatic void model_clear();
        exp_line.delete();
        exp_busy.delete();
        exp_done.delete();
    endfunction

    task automatic send_byte(input logic [7:0] d);
        tx_data_in = d;
        tx_valid   = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        tx_valid   = 1'b1;
        tx_data_in = 8'h55;
        repeat (3) @(negedge clk);
        checks += 5;
        if (tx_serial_out !== 1'b1) begin errors++; $display("FAIL reset_line got=%b want=1", tx_serial_out); end
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", tx_done); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", tx_ready); end
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b want=1", tx_ready); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL release_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_single();
        model_clear();
        model_frame(8'hA5, 2'b00, 1'b0, 1'b1);
        model_tail();
        send_byte(8'hA5);
        checks += 2;
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_accept got=%0d want=1", fifo_count); end
        if (tx_serial_out !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL single_still_idle line=%b busy=%b want 1 0", tx_serial_out, tx_busy);
        end
        @(negedge clk);
        foreach (exp_line[i]) begin
            checks++;
            if (tx_serial_out !== exp_line[i] || tx_busy !== exp_busy[i] || tx_done !== exp_done[i]) begin
                errors++;
                $display("FAIL single_frame idx=%0d line/busy/done got=%b%b%b want=%b%b%b",
                         i, tx_serial_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_serial_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
                errors++; $display("FAIL single_idle idx=%0d line=%b busy=%b count=%0d want 1 0 0",
                                   i, tx_serial_out, tx_busy, fifo_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_parity();
        logic [7:0] data [6];
        logic [1:0] modes [6];
        data[0] = 8'h07; modes[0] = 2'b01;
        data[1] = 8'h07; modes[1] = 2'b10;
        data[2] = 8'h00; modes[2] = 2'b01;
        data[3] = 8'($urandom); modes[3] = 2'b11;
        data[4] = 8'($urandom); modes[4] = 2'b01;
        data[5] = 8'($urandom); modes[5] = 2'b10;
        for (int t = 0; t < 6; t++) begin
            parity_mode = modes[t];
            model_clear();
            model_frame(data[t], modes[t], 1'b0, 1'b1);
            model_tail();
            send_byte(data[t]);
            @(negedge clk);
            foreach (exp_line[i]) begin
                checks++;
                if (tx_serial_out !== exp_line[i] || tx_busy !== exp_busy[i] || tx_done !== exp_done[i]) begin
                    errors++;
                    $display("FAIL parity_frame case=%0d idx=%0d line/busy/done got=%b%b%b want=%b%b%b",
                             t, i, tx_serial_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]);
                end
                @(negedge clk);
            end
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_stop2();
        stop2       = 1'b1;
        parity_mode = 2'b00;
        model_clear();
        model_frame(8'hFF, 2'b00, 1'b1, 1'b1);
        model_tail();
        send_byte(8'hFF);
        @(negedge clk);
        foreach (exp_line[i]) begin
            if (i == 12) begin
                stop2       = 1'b0;
                parity_mode = 2'b01;
            end
            checks++;
            if (tx_serial_out !== exp_line[i] || tx_busy !== exp_busy[i] || tx_done !== exp_done[i]) begin
                errors++;
                $display("FAIL stop2_frame idx=%0d line/busy/done got=%b%b%b want=%b%b%b",
                         i, tx_serial_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]);
            end
            @(negedge clk);
        end
        stop2       = 1'b0;
        parity_mode = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [6];
        int e0, acc6, d0, n;
        bit timed_out;
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
        model_clear();
        for (int k = 0; k < 6; k++) model_frame(b[k], 2'b00, 1'b0, k == 0);
        model_tail();
        d0 = done_cnt;
        e0 = 0;
        acc6 = 0;
        timed_out = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    tx_data_in = b[k];
                    tx_valid   = 1'b1;
                    n = 0;
                    while (tx_ready !== 1'b1 && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 500) timed_out = 1'b1;
                    @(negedge clk);
                    if (k == 0) e0 = cyc;
                    if (k == 5) acc6 = cyc;
                    if (k == 4) begin
                        checks += 2;
                        if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got=%0d want=4", fifo_count); end
                        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b want=0", tx_ready); end
                    end
                end
                tx_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                foreach (exp_line[i]) begin
                    checks++;
                    if (tx_serial_out !== exp_line[i] || tx_busy !== exp_busy[i] || tx_done !== exp_done[i]) begin
                        errors++;
                        $display("FAIL b2b_frames idx=%0d line/busy/done got=%b%b%b want=%b%b%b",
                                 i, tx_serial_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]);
                    end
                    @(negedge clk);
                end
            end
        join
        checks += 3;
        if (timed_out) begin errors++; $display("FAIL b2b_accept_timeout got=timeout want=accept"); end
        if (acc6 - e0 != 52) begin errors++; $display("FAIL b2b_sixth_accept got=%0d want=52", acc6 - e0); end
        if (done_cnt - d0 != 6) begin errors++; $display("FAIL b2b_done_pulses got=%0d want=6", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [3];
        logic [7:0] fresh;
        for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            tx_data_in = b[k];
            tx_valid   = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd2) begin errors++; $display("FAIL rmid_queued got=%0d want=2", fifo_count); end
        repeat (21) @(negedge clk);
        checks++;
        if (tx_serial_out !== b[0][3]) begin errors++; $display("FAIL rmid_data_bit3 got=%b want=%b", tx_serial_out, b[0][3]); end
        reset_n = 1'b0;
        @(negedge clk);
        checks += 4;
        if (tx_serial_out !== 1'b1) begin errors++; $display("FAIL rmid_line got=%b want=1", tx_serial_out); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b want=0", tx_busy); end
        if (tx_done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b want=0", tx_done); end
        reset_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            checks++;
            if (tx_serial_out !== 1'b1 || tx_busy !== 1'b0) begin
                errors++; $display("FAIL rmid_residual idx=%0d line=%b busy=%b want 1 0", i, tx_serial_out, tx_busy);
            end
        end
        fresh = 8'($urandom);
        model_clear();
        model_frame(fresh, 2'b00, 1'b0, 1'b1);
        model_tail();
        send_byte(fresh);
        @(negedge clk);
        foreach (exp_line[i]) begin
            checks++;
            if (tx_serial_out !== exp_line[i] || tx_busy !== exp_busy[i] || tx_done !== exp_done[i]) begin
                errors++;
                $display("FAIL rmid_new_frame idx=%0d line/busy/done got=%b%b%b want=%b%b%b",
                         i, tx_serial_out, tx_busy, tx_done, exp_line[i], exp_busy[i], exp_done[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent [10];
        int bursts [4];
        int idx, n;
        bit dup, timed_out;
        logic [7:0] v;
        bursts[0] = 3; bursts[1] = 1; bursts[2] = 4; bursts[3] = 2;
        for (int i = 0; i < 10; i++) begin
            do begin
                v = 8'($urandom);
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (sent[j] == v) dup = 1'b1;
            end while (dup);
            sent[i] = v;
        end
        rx_q.delete();
        rx_en = 1'b1;
        idx = 0;
        timed_out = 1'b0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < bursts[g]; k++) begin
                tx_data_in = sent[idx];
                tx_valid   = 1'b1;
                n = 0;
                while (tx_ready !== 1'b1 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 500) timed_out = 1'b1;
                @(negedge clk);
                idx++;
            end
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        n = 0;
        while ((tx_busy !== 1'b0 || fifo_count !== 3'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timed_out = 1'b1;
        repeat (5) @(negedge clk);
        rx_en = 1'b0;
        checks += 2;
        if (timed_out) begin errors++; $display("FAIL wrap_timeout got=timeout want=drained"); end
        if (rx_q.size() != 10) begin errors++; $display("FAIL wrap_frame_count got=%0d want=10", rx_q.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= rx_q.size()) begin
                errors++; $display("FAIL wrap_order idx=%0d got=missing want=%h", i, sent[i]);
            end else if (rx_q[i] !== sent[i]) begin
                errors++; $display("FAIL wrap_order idx=%0d got=%h want=%h", i, rx_q[i], sent[i]);
            end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        tx_valid    = 1'b0;
        tx_data_in  = 8'h00;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
